// File: rtl/fine_time_classifier_if.sv
// Local-bus register port of the fine-time classifier.
// The master drives the strobes and write data; the slave returns OR-bussed read data.
interface fine_time_classifier_if;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic [7:0]  Address;
    logic        Read;
    logic        Write;

    modport master (output DataIn, Address, Read, Write, input DataOut);
    modport slave  (input DataIn, Address, Read, Write, output DataOut);
endinterface

// File: rtl/fine_time_classifier.sv
// Fine-time leading-edge decoder: boundary-spanning edge detect, windowed class hits, holdoff.
// Define COUNTERS_EN to add per-class 16-bit saturating hit counters on the local bus.
module fine_time_classifier #(
    parameter int         WIDTH  = 32,
    parameter int         NCLASS = 3,
    parameter int         RUN    = 3,
    parameter logic [7:0] BASE   = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         sample_in,
    input  logic                     sample_valid,
    output logic                     edge_valid,
    output logic [$clog2(WIDTH)-1:0] edge_time,
    output logic [NCLASS-1:0]        class_hit,
    output logic [WIDTH-1:0]         decode_out,
    fine_time_classifier_if.slave    bus
);
    localparam int TW = $clog2(WIDTH);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [WIDTH-1:0]              r_s1;
    logic                          r_s1_vld;
    logic [RUN-1:0]                r_tail;
    state_t                        r_state;
    logic [7:0]                    r_cnt;
    logic [15:0]                   r_cfg;
    logic [NCLASS-1:0][WIDTH-1:0]  r_win;

    logic [WIDTH+RUN-1:0]          w_x;
    logic [WIDTH-1:0]              w_decode;
    logic [WIDTH-1:0]              w_dec_gated;
    logic [TW-1:0]                 w_low;
    logic [NCLASS-1:0]             w_hit;
    logic [7:0]                    w_off;
    logic [31:0]                   w_rd;

    assign w_off = bus.Address - BASE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1     <= sample_in;
            r_s1_vld <= sample_valid;
        end
    end

    // The tail carries the previous sample's top RUN slices so a run can straddle samples.
    assign w_x = {r_s1, r_tail};

    always_comb begin
        w_decode = '0;
        for (int k = 0; k < WIDTH; k++)
            w_decode[k] = (&w_x[k +: RUN]) & ~w_x[k+RUN];
    end

    assign w_dec_gated = (r_s1_vld && r_cfg[0] && r_state == IDLE) ? w_decode : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tail     <= '0;
            decode_out <= '0;
            r_state    <= IDLE;
            r_cnt      <= '0;
        end else begin
            r_tail     <= r_s1_vld ? r_s1[WIDTH-1 -: RUN] : '0;
            decode_out <= w_dec_gated;
            case (r_state)
                IDLE: if (|w_dec_gated && r_cfg[15:8] != 8'd0) begin
                    r_cnt   <= r_cfg[15:8];
                    r_state <= HOLD;
                end
                HOLD: begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_low = '0;
        for (int k = WIDTH-1; k >= 0; k--)
            if (decode_out[k]) w_low = TW'(k);
    end

    for (genvar i = 0; i < NCLASS; i++) begin : g_cls
        assign w_hit[i] = (|(decode_out & r_win[i])) & r_cfg[i+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_valid <= 1'b0;
            edge_time  <= '0;
            class_hit  <= '0;
        end else begin
            edge_valid <= |decode_out;
            edge_time  <= w_low;
            class_hit  <= w_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg <= 16'h00FF;
            r_win <= '1;
        end else if (bus.Write) begin
            if (w_off == 8'd0) r_cfg <= bus.DataIn[15:0];
            for (int i = 0; i < NCLASS; i++)
                if (w_off == 8'(i + 1)) r_win[i] <= bus.DataIn[WIDTH-1:0];
        end
    end

`ifdef COUNTERS_EN
    logic [NCLASS-1:0][15:0] r_hits;

    // A clearing write outranks a same-cycle hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hits <= '0;
        end else begin
            for (int i = 0; i < NCLASS; i++) begin
                if (bus.Write && w_off == 8'(NCLASS + 1 + i))
                    r_hits[i] <= '0;
                else if (class_hit[i] && r_hits[i] != 16'hFFFF)
                    r_hits[i] <= r_hits[i] + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        w_rd = '0;
        if (w_off == 8'd0) w_rd = {16'h0, r_cfg};
        for (int i = 0; i < NCLASS; i++)
            if (w_off == 8'(i + 1)) w_rd[WIDTH-1:0] = r_win[i];
`ifdef COUNTERS_EN
        for (int i = 0; i < NCLASS; i++)
            if (w_off == 8'(NCLASS + 1 + i)) w_rd = {16'h0, r_hits[i]};
`endif
    end

    assign bus.DataOut = bus.Read ? w_rd : '0;
endmodule

// File: tb/tb_fine_time_classifier.sv
// Bench for fine_time_classifier: vector table, hand-written corner sequences and a
// randomized stream checked against a slice-stream reference model.
module tb_fine_time_classifier;
    localparam int         WIDTH  = 32;
    localparam int         NCLASS = 3;
    localparam int         RUN    = 3;
    localparam logic [7:0] BASE   = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        edge_valid;
    logic [4:0]  edge_time;
    logic [2:0]  class_hit;
    logic [31:0] decode_out;

    fine_time_classifier_if bif();

    fine_time_classifier #(.WIDTH(WIDTH), .NCLASS(NCLASS), .RUN(RUN), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .edge_valid(edge_valid), .edge_time(edge_time), .class_hit(class_hit),
        .decode_out(decode_out), .bus(bif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ev;
        logic [4:0]  et;
        logic [2:0]  ch;
        logic [31:0] dec;
    } exp_t;

    typedef struct {
        logic [31:0] cfg, w0, w1, w2, s;
        logic        ev;
        logic [4:0]  et;
        logic [2:0]  ch;
        logic [31:0] dec;
    } vec_t;

    exp_t        q[$];
    logic [31:0] m_cfg;
    logic [31:0] m_win[3];
    logic [31:0] m_prev;
    bit          m_pv;
    int          m_dead;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Edge at slice k: slice k is 0 and the RUN slices just before it in time are all 1.
    function automatic logic [31:0] m_edges(logic [31:0] s, logic [31:0] prev, bit pv);
        logic [63:0] stream;
        logic [31:0] r;
        bit ok;
        stream = {s, (pv ? prev : 32'h0)};
        r = '0;
        for (int k = 0; k < 32; k++) begin
            ok = (stream[32+k] == 1'b0);
            for (int j = 1; j <= RUN; j++)
                if (!stream[32+k-j]) ok = 0;
            r[k] = ok;
        end
        return r;
    endfunction

    function automatic logic [4:0] lowest(logic [31:0] d);
        logic [4:0] r;
        r = '0;
        for (int k = 31; k >= 0; k--)
            if (d[k]) r = 5'(k);
        return r;
    endfunction

    task automatic model_reset();
        m_cfg = 32'hFF;
        for (int i = 0; i < 3; i++) m_win[i] = '1;
        m_prev = '0;
        m_pv   = 0;
        m_dead = 0;
        q.delete();
    endtask

    // One clock: drive a sample, predict its outputs, and check whatever is due now.
    task automatic cyc(input logic [31:0] s, input logic v);
        exp_t e;
        logic [31:0] d;
        sample_in    = s;
        sample_valid = v;
        d = (v && m_cfg[0] && m_dead == 0) ? m_edges(s, m_prev, m_pv) : 32'h0;
        if (m_dead > 0) m_dead--;
        else if (d != 0) m_dead = int'(m_cfg[15:8]);
        m_prev = s;
        m_pv   = v;
        e.dec = d;
        e.ev  = (d != 0);
        e.et  = lowest(d);
        for (int i = 0; i < 3; i++) e.ch[i] = ((d & m_win[i]) != 0) && m_cfg[i+1];
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 3) begin
            e = q.pop_front();
            chk("model_edge_valid", 64'(edge_valid), 64'(e.ev));
            chk("model_edge_time",  64'(edge_time),  64'(e.et));
            chk("model_class_hit",  64'(class_hit),  64'(e.ch));
            chk("model_decode_out", 64'(decode_out), 64'(q[0].dec));
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bif.Address = a;
        bif.DataIn  = d;
        bif.Write   = 1'b1;
        cyc(32'h0, 1'b0);
        bif.Write   = 1'b0;
        if (a == BASE) m_cfg = {16'h0, d[15:0]};
        for (int i = 0; i < 3; i++)
            if (a == BASE + 8'(i + 1)) m_win[i] = d;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bif.Address = a;
        bif.Read    = 1'b1;
        #1;
        d = bif.DataOut;
        bif.Read    = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[12];
        logic [31:0] rd, c, s;
        logic [8:0]  evs;
        bit          saw;

        // cfg, win0, win1, win2, sample, ev, et, class_hit, decode
        vt[0]  = '{32'hFF, '1, '1, '1, 32'h0000_000E, 1, 4,  3'b111, 32'h0000_0010};
        vt[1]  = '{32'hFF, '1, '1, '1, 32'h0000_0000, 0, 0,  3'b000, 32'h0};
        vt[2]  = '{32'hFF, '1, '1, '1, 32'hFFFF_FFFF, 0, 0,  3'b000, 32'h0};
        vt[3]  = '{32'hFF, '1, '1, '1, 32'h0000_0007, 1, 3,  3'b111, 32'h0000_0008};
        vt[4]  = '{32'hFF, '1, '1, '1, 32'h0000_0003, 0, 0,  3'b000, 32'h0};
        vt[5]  = '{32'hFF, '1, '1, '1, 32'h0000_0F0E, 1, 4,  3'b111, 32'h0000_1010};
        vt[6]  = '{32'hFF, '1, '1, '1, 32'h7000_0007, 1, 3,  3'b111, 32'h8000_0008};
        vt[7]  = '{32'hFF, '1, '1, '1, 32'h7000_0000, 1, 31, 3'b111, 32'h8000_0000};
        // class 0 off (CFG bit1=0), class 1 window+enable match, class 2 blocked twice
        vt[8]  = '{32'h05, '1, 32'h10, 32'h0, 32'h0000_000E, 1, 4, 3'b010, 32'h0000_0010};
        vt[9]  = '{32'h00, '1, '1, '1, 32'h0000_000E, 0, 0,  3'b000, 32'h0};
        vt[10] = '{32'h0F, 32'h8, 32'h10, 32'h1000, 32'h0000_0F0E, 1, 4, 3'b110, 32'h0000_1010};
        vt[11] = '{32'hFF, 32'h8000_0000, 32'h0, 32'h0, 32'h7000_0007, 1, 3, 3'b001, 32'h8000_0008};

        bif.Address = '0; bif.DataIn = '0; bif.Read = 1'b0; bif.Write = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        chk("rst_edge_valid", 64'(edge_valid), 64'd0);
        chk("rst_edge_time",  64'(edge_time),  64'd0);
        chk("rst_class_hit",  64'(class_hit),  64'd0);
        chk("rst_decode_out", 64'(decode_out), 64'd0);
        bus_read(BASE, rd);             chk("rst_cfg", 64'(rd), 64'h0000_00FF);
        bus_read(BASE + 8'd1, rd);      chk("rst_win0", 64'(rd), 64'hFFFF_FFFF);
        bus_read(BASE + 8'd3, rd);      chk("rst_win2", 64'(rd), 64'hFFFF_FFFF);
        bus_read(BASE + 8'd7, rd);      chk("unmapped_read", 64'(rd), 64'd0);
        bif.Address = BASE; bif.Read = 1'b0; #1;
        chk("no_read_strobe", 64'(bif.DataOut), 64'd0);

        // vector table
        for (int i = 0; i < 12; i++) begin
            bus_write(BASE,        vt[i].cfg);
            bus_write(BASE + 8'd1, vt[i].w0);
            bus_write(BASE + 8'd2, vt[i].w1);
            bus_write(BASE + 8'd3, vt[i].w2);
            cyc(vt[i].s, 1'b1);
            cyc(32'h0, 1'b0);
            chk($sformatf("vec%0d_decode", i), 64'(decode_out), 64'(vt[i].dec));
            cyc(32'h0, 1'b0);
            chk($sformatf("vec%0d_edge_valid", i), 64'(edge_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_edge_time", i),  64'(edge_time),  64'(vt[i].et));
            chk($sformatf("vec%0d_class_hit", i),  64'(class_hit),  64'(vt[i].ch));
            cyc(32'h0, 1'b0);
        end

        // edge straddling two consecutive valid samples
        do_reset();
        cyc(32'hE000_0000, 1'b1);
        cyc(32'h0, 1'b1);
        chk("bnd_first_decode", 64'(decode_out), 64'd0);
        cyc(32'h0, 1'b0);
        chk("bnd_second_decode", 64'(decode_out), 64'h1);
        chk("bnd_first_ev", 64'(edge_valid), 64'd0);
        cyc(32'h0, 1'b0);
        chk("bnd_ev", 64'(edge_valid), 64'd1);
        chk("bnd_et", 64'(edge_time), 64'd0);

        // an invalid cycle between the samples must break the run
        saw = 0;
        cyc(32'hE000_0000, 1'b1);
        cyc(32'h0, 1'b0);
        saw |= edge_valid | (decode_out != 0);
        cyc(32'h0, 1'b1);
        saw |= edge_valid | (decode_out != 0);
        repeat (3) begin
            cyc(32'h0, 1'b0);
            saw |= edge_valid | (decode_out != 0);
        end
        chk("gap_no_edge", 64'(saw), 64'd0);

        // holdoff of 3 across six back-to-back hits
        do_reset();
        bus_write(BASE, 32'h0000_03FF);
        for (int i = 0; i < 9; i++) begin
            cyc((i < 6) ? 32'hE : 32'h0, (i < 6));
            evs[i] = edge_valid;
        end
        chk("holdoff_pattern", 64'(evs), 64'(9'b001000100));

        // reset while in HOLD clears everything and the next hit is reported
        bus_write(BASE, 32'h0000_03FF);
        cyc(32'hE, 1'b1);
        cyc(32'h0, 1'b0);
        chk("hold_pre_rst_decode", 64'(decode_out), 64'h10);
        rst = 1'b1;
        #1;
        chk("async_rst_decode", 64'(decode_out), 64'd0);
        do_reset();
        bus_read(BASE, rd);
        chk("rst_restores_cfg", 64'(rd), 64'h0000_00FF);
        cyc(32'hE, 1'b1);
        cyc(32'h0, 1'b0);
        cyc(32'h0, 1'b0);
        chk("post_rst_ev", 64'(edge_valid), 64'd1);
        chk("post_rst_et", 64'(edge_time), 64'd4);

        // randomized configurations and streams against the model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            c = {16'h0, 8'($urandom_range(0, 4)), 4'h0, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0)};
            bus_write(BASE, c);
            bus_write(BASE + 8'd1, (r == 0) ? 32'hFFFF_FFFF : $urandom);
            bus_write(BASE + 8'd2, $urandom | $urandom);
            bus_write(BASE + 8'd3, $urandom & $urandom);
            bus_read(BASE, rd);
            chk("rand_cfg_rb", 64'(rd), 64'(c & 32'hFFFF));
            bus_read(BASE + 8'd2, rd);
            chk("rand_win1_rb", 64'(rd), 64'(m_win[1]));
            for (int n = 0; n < 250; n++) begin
                case ($urandom_range(0, 3))
                    0: s = $urandom;
                    1: s = 32'hE << $urandom_range(0, 28);
                    2: s = $urandom & $urandom;
                    default: s = ($urandom_range(0, 1) != 0) ? 32'hE000_0000 : 32'h0;
                endcase
                cyc(s, ($urandom_range(0, 4) != 0));
            end
            repeat (3) cyc(32'h0, 1'b0);
        end

`ifdef COUNTERS_EN
        do_reset();
        repeat (32'h1_0005) cyc(32'hE, 1'b1);
        repeat (4) cyc(32'h0, 1'b0);
        bus_read(BASE + 8'd4, rd);  chk("cnt0_sat", 64'(rd), 64'hFFFF);
        bus_read(BASE + 8'd6, rd);  chk("cnt2_sat", 64'(rd), 64'hFFFF);
        bus_write(BASE + 8'd4, 32'h0);
        bus_read(BASE + 8'd4, rd);  chk("cnt0_clear", 64'(rd), 64'h0);
        bus_read(BASE + 8'd5, rd);  chk("cnt1_kept", 64'(rd), 64'hFFFF);
`else
        do_reset();
        cyc(32'hE, 1'b1);
        repeat (3) cyc(32'h0, 1'b0);
        bus_read(BASE + 8'd4, rd);  chk("cnt_addr_zero", 64'(rd), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
